// File: rtl/fb_bucket_writer.sv
// Byte-stream to double-banked frame memory writer; writes land one cycle after acceptance, bank swap one cycle after a clock_cycle rise.
// data_ready is low only while a full bucket waits for the swap. Optional trailing XOR checksum: FB_WRITER_CHECKSUM_EN.
module fb_bucket_writer #(
  parameter int         FB_SIZE     = 16,
  parameter int         FRAME_BYTES = 64,
  parameter int         OFS_WIDTH   = 20,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic [7:0]         data_in,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic               clock_cycle,
  output logic               mem_we,
  output logic [OFS_WIDTH:0] mem_addr,
  output logic [7:0]         mem_wdata,
  output logic               read_bank,
  output logic               next_fb,
  output logic [7:0]         frame_cnt,
  output logic               err
);

  localparam logic [OFS_WIDTH-1:0] LAST_OFS  = OFS_WIDTH'(FB_SIZE * FRAME_BYTES - 1);
  localparam logic [11:0]          LAST_BYTE = 12'(FRAME_BYTES - 1);

`ifdef FB_WRITER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, WAIT_SWAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP} state_t;
`endif

  state_t               state_q, state_d;
  logic                 read_bank_q, read_bank_d;
  logic [OFS_WIDTH-1:0] ofs_q, ofs_d;
  logic [11:0]          byte_q, byte_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic                 mem_we_q, mem_we_d;
  logic [OFS_WIDTH:0]   mem_addr_q, mem_addr_d;
  logic [7:0]           mem_wdata_q, mem_wdata_d;
  logic                 next_fb_q, next_fb_d;
  logic                 cc_prev_q, cc_prev_d;
`ifdef FB_WRITER_CHECKSUM_EN
  logic [7:0]           xor_q, xor_d;
  logic                 err_q, err_d;
`endif

  logic accept;
  logic cc_rise;

  assign data_ready = (state_q != WAIT_SWAP);
  assign accept     = data_valid & data_ready;
  assign cc_rise    = clock_cycle & ~cc_prev_q;

  always_comb begin
    state_d     = state_q;
    read_bank_d = read_bank_q;
    ofs_d       = ofs_q;
    byte_d      = byte_q;
    frame_cnt_d = frame_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    next_fb_d   = 1'b0;
    cc_prev_d   = clock_cycle;
`ifdef FB_WRITER_CHECKSUM_EN
    xor_d       = xor_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept && data_in == SYNC_BYTE) begin
          state_d     = LOAD;
          ofs_d       = '0;
          byte_d      = '0;
          frame_cnt_d = '0;
`ifdef FB_WRITER_CHECKSUM_EN
          xor_d       = '0;
`endif
        end
      end
      LOAD: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = {~read_bank_q, ofs_q};
          mem_wdata_d = data_in;
          ofs_d       = ofs_q + OFS_WIDTH'(1);
`ifdef FB_WRITER_CHECKSUM_EN
          xor_d       = xor_q ^ data_in;
`endif
          // byte_q tracks position within the frame so no divider is needed
          if (byte_q == LAST_BYTE) begin
            byte_d      = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            byte_d = byte_q + 12'd1;
          end
          if (ofs_q == LAST_OFS) begin
`ifdef FB_WRITER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = WAIT_SWAP;
`endif
          end
        end
      end
`ifdef FB_WRITER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          if (data_in == xor_q) begin
            state_d = WAIT_SWAP;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      WAIT_SWAP: begin
        if (cc_rise) begin
          read_bank_d = ~read_bank_q;
          next_fb_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      read_bank_q <= 1'b0;
      ofs_q       <= '0;
      byte_q      <= '0;
      frame_cnt_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      next_fb_q   <= 1'b0;
      cc_prev_q   <= 1'b0;
`ifdef FB_WRITER_CHECKSUM_EN
      xor_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      read_bank_q <= read_bank_d;
      ofs_q       <= ofs_d;
      byte_q      <= byte_d;
      frame_cnt_q <= frame_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      next_fb_q   <= next_fb_d;
      cc_prev_q   <= cc_prev_d;
`ifdef FB_WRITER_CHECKSUM_EN
      xor_q       <= xor_d;
      err_q       <= err_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign read_bank = read_bank_q;
  assign next_fb   = next_fb_q;
  assign frame_cnt = frame_cnt_q;
`ifdef FB_WRITER_CHECKSUM_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule
